reg_bank_mp: RTL and testbench

REG_BANK_MP -- requirements
Module: reg_bank_mp

---
 rtl/reg_bank_mp_pkg.sv | 22 ++
 rtl/reg_bank_mp_if.sv | 30 +++
 rtl/reg_bank_mp_rdport.sv | 39 +++
 rtl/reg_bank_mp.sv | 65 ++++++
 tb/tb_reg_bank_mp.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/reg_bank_mp_pkg.sv
// Shared CPU package: address-width helper and zero-register encodings,
// used by the register bank, the ALU and the control FSM.
package reg_bank_mp_pkg;

    localparam int ZERO_REG_OFF = 0;
    localparam int ZERO_REG_ON  = 1;

    // Smallest AW with 2**AW >= n; returns 1 for n <= 2 so an address is never 0 bits wide.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << r) < n) r = k + 1;
        end
        return r;
    endfunction

    function automatic bit is_hardwired(input int addr, input int zero_reg);
        return (zero_reg == ZERO_REG_ON) && (addr == 0);
    endfunction

endpackage

// File: rtl/reg_bank_mp_if.sv
// Write/read bus of the multi-port register bank.
interface reg_bank_mp_if
    import reg_bank_mp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int AW = clog2(DEPTH);

    logic             wrr;
    logic [AW-1:0]    wp;
    logic [WIDTH-1:0] data;
    logic             rdr;
    logic [AW-1:0]    pa;
    logic [AW-1:0]    pb;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic             rd_valid;

    modport master (
        output wrr, wp, data, rdr, pa, pb,
        input  p, q, rd_valid
    );

    modport slave (
        input  wrr, wp, data, rdr, pa, pb,
        output p, q, rd_valid
    );

endinterface

// File: rtl/reg_bank_mp_rdport.sv
// One registered read port: write-first bypass, hardwired-zero override,
// output register loaded only on read enable.
module reg_bank_rdport
    import reg_bank_mp_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int AW       = 3,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdr,
    input  logic [AW-1:0]    addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wp,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] rd_word,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sel_p0;
    logic [WIDTH-1:0] dout_p1;

    // Stage p0: select stored word, in-flight write, or hardwired zero
    always_comb begin
        sel_p0 = rd_word;
        if (wr_en && (addr == wp)) sel_p0 = wdata;
        if (is_hardwired(int'(addr), ZERO_REG)) sel_p0 = '0;
    end

    // Stage p1: output register
    always_ff @(posedge clk) begin
        if (rst)      dout_p1 <= '0;
        else if (rdr) dout_p1 <= sel_p0;
    end

    assign dout = dout_p1;

endmodule

// File: rtl/reg_bank_mp.sv
// Register bank: one write port, two registered read ports sharing one
// read enable, optional hardwired-zero register 0.
module reg_bank_mp
    import reg_bank_mp_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0
) (
    input  logic         clk,
    input  logic         rst,
    reg_bank_mp_if.slave bus
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_en;
    logic             vld_p1;

    // A write aimed at the hardwired register is dropped here, so neither
    // storage nor the read-port bypass ever sees it.
    assign wr_en = bus.wrr && !is_hardwired(int'(bus.wp), ZERO_REG);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[bus.wp] <= bus.data;
        end
    end

    // Stage p1: read-valid pulse
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= bus.rdr;
    end

    reg_bank_rdport #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_port_a (
        .clk     (clk),
        .rst     (rst),
        .rdr     (bus.rdr),
        .addr    (bus.pa),
        .wr_en   (wr_en),
        .wp      (bus.wp),
        .wdata   (bus.data),
        .rd_word (regs[bus.pa]),
        .dout    (bus.p)
    );

    reg_bank_rdport #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_port_b (
        .clk     (clk),
        .rst     (rst),
        .rdr     (bus.rdr),
        .addr    (bus.pb),
        .wr_en   (wr_en),
        .wp      (bus.wp),
        .wdata   (bus.data),
        .rd_word (regs[bus.pb]),
        .dout    (bus.q)
    );

    assign bus.rd_valid = vld_p1;

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench for reg_bank_mp: default bank, hardwired-zero bank (sharing
// the default bank's stimulus) and a 32x16 bank for the all-pairs sweep.
module tb_reg_bank_mp;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_bank_mp_if #(.WIDTH(16), .DEPTH(8))  ba ();
    reg_bank_mp_if #(.WIDTH(16), .DEPTH(8))  bz ();
    reg_bank_mp_if #(.WIDTH(32), .DEPTH(16)) bw ();

    assign bz.wrr  = ba.wrr;
    assign bz.wp   = ba.wp;
    assign bz.data = ba.data;
    assign bz.rdr  = ba.rdr;
    assign bz.pa   = ba.pa;
    assign bz.pb   = ba.pb;

    reg_bank_mp #(.WIDTH(16), .DEPTH(8),  .ZERO_REG(0)) dut_a (.clk(clk), .rst(rst), .bus(ba));
    reg_bank_mp #(.WIDTH(16), .DEPTH(8),  .ZERO_REG(1)) dut_z (.clk(clk), .rst(rst), .bus(bz));
    reg_bank_mp #(.WIDTH(32), .DEPTH(16), .ZERO_REG(0)) dut_w (.clk(clk), .rst(rst), .bus(bw));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic w, input logic [2:0] wp, input logic [15:0] d,
                           input logic r, input logic [2:0] pa, input logic [2:0] pb);
        ba.wrr = w; ba.wp = wp; ba.data = d; ba.rdr = r; ba.pa = pa; ba.pb = pb;
    endtask

    function automatic logic [31:0] wval(input int i);
        return 32'(i + 1) * 32'h1000_0F01;
    endfunction

    initial begin
        rst = 1'b1;
        drive_a(0, 0, 16'h0, 0, 0, 0);
        bw.wrr = 0; bw.wp = '0; bw.data = '0; bw.rdr = 0; bw.pa = '0; bw.pb = '0;
        step(); step();
        chk("rst_p",   32'(ba.p), 32'h0);
        chk("rst_q",   32'(ba.q), 32'h0);
        chk("rst_vld", 32'(ba.rd_valid), 32'h0);
        chk("rst_w_vld", 32'(bw.rd_valid), 32'h0);

        // first read after reset
        rst = 1'b0;
        drive_a(0, 0, 16'h0, 1, 3, 7);
        step();
        chk("rd0_p",   32'(ba.p), 32'h0);
        chk("rd0_q",   32'(ba.q), 32'h0);
        chk("rd0_vld", 32'(ba.rd_valid), 32'h1);
        drive_a(0, 0, 16'h0, 0, 3, 7);
        step();
        chk("vld_drop", 32'(ba.rd_valid), 32'h0);

        // write r5 then read it next cycle
        drive_a(1, 5, 16'h1234, 0, 0, 0);
        step();
        drive_a(0, 0, 16'h0, 1, 5, 5);
        step();
        chk("r5_p",   32'(ba.p), 32'h1234);
        chk("r5_q",   32'(ba.q), 32'h1234);
        chk("r5_vld", 32'(ba.rd_valid), 32'h1);

        // rdr=0 holds outputs; data toggling with wrr=0 has no effect
        drive_a(0, 5, 16'hDEAD, 0, 3, 3);
        step();
        chk("hold_p",   32'(ba.p), 32'h1234);
        chk("hold_vld", 32'(ba.rd_valid), 32'h0);
        drive_a(0, 0, 16'h0, 1, 5, 0);
        step();
        chk("nowr_r5", 32'(ba.p), 32'h1234);

        // write-first bypass on port A, stored value on port B
        drive_a(1, 1, 16'h0011, 0, 0, 0);
        step();
        drive_a(1, 2, 16'hBEEF, 1, 2, 1);
        step();
        chk("byp_p", 32'(ba.p), 32'hBEEF);
        chk("byp_q", 32'(ba.q), 32'h0011);
        drive_a(0, 0, 16'h0, 1, 2, 5);
        step();
        chk("r2_p", 32'(ba.p), 32'hBEEF);
        chk("r5_keep", 32'(ba.q), 32'h1234);

        // write to r0 with simultaneous read: plain bank bypasses, zero bank does not
        drive_a(1, 0, 16'hFFFF, 1, 0, 1);
        step();
        chk("z_byp_p", 32'(bz.p), 32'h0);
        chk("z_byp_q", 32'(bz.q), 32'h0011);
        chk("a_r0_byp", 32'(ba.p), 32'hFFFF);
        drive_a(0, 0, 16'h0, 1, 0, 0);
        step();
        chk("z_r0_later", 32'(bz.p), 32'h0);
        chk("a_r0_later", 32'(ba.p), 32'hFFFF);

        // reset wins over a concurrent write and read
        drive_a(1, 4, 16'hAAAA, 0, 0, 0);
        step();
        drive_a(0, 0, 16'h0, 1, 4, 4);
        step();
        chk("r4_pre", 32'(ba.p), 32'hAAAA);
        rst = 1'b1;
        drive_a(1, 4, 16'h5555, 1, 4, 5);
        step();
        chk("rstw_vld", 32'(ba.rd_valid), 32'h0);
        chk("rstw_p",   32'(ba.p), 32'h0);
        rst = 1'b0;
        drive_a(0, 0, 16'h0, 1, 4, 5);
        step();
        chk("post_r4",  32'(ba.p), 32'h0);
        chk("post_r5",  32'(ba.q), 32'h0);
        chk("post_vld", 32'(ba.rd_valid), 32'h1);
        drive_a(1, 6, 16'h6666, 1, 6, 0);
        step();
        chk("post_wr_byp", 32'(ba.p), 32'h6666);
        drive_a(0, 0, 16'h0, 0, 0, 0);

        // 32x16: fill every register, then read every (pa, pb) pair
        for (int i = 0; i < 16; i++) begin
            bw.wrr = 1; bw.wp = 4'(i); bw.data = wval(i);
            step();
        end
        bw.wrr = 0;
        bw.rdr = 1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                bw.pa = 4'(i); bw.pb = 4'(j);
                step();
                chk($sformatf("w_p[%0d]", i), bw.p, wval(i));
                chk($sformatf("w_q[%0d]", j), bw.q, wval(j));
            end
        end
        bw.rdr = 0;
        step();
        chk("w_vld_end", 32'(bw.rd_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
